// File: rtl/ptmch_trg_multi.sv
// rtl/ptmch_trg_multi.sv - SPI opcode pattern matcher driving per-channel trigger pulses (optional HIT_CNT via PTMCH_TRG_HIT_CNT_EN)
module ptmch_trg_multi #(
    parameter int OPC_BITS = 12,
    parameter int NUM_CH   = 5,
    parameter int PLS_W    = 16
) (
    input  logic                         CLK160M,
    input  logic                         RESET,
    input  logic                         SPI_CS,
    input  logic                         SPI_CLK,
    input  logic                         SPI_MOSI,
    input  logic [NUM_CH*OPC_BITS-1:0]   PAT,
    input  logic [NUM_CH*OPC_BITS-1:0]   MSK,
    input  logic [NUM_CH-1:0]            CH_EN,
    input  logic                         TRG_MODE,
    output logic [NUM_CH-1:0]            TRG_PLS,
    output logic                         OPC_VLD,
    output logic [OPC_BITS-1:0]          OPC_DATA
`ifdef PTMCH_TRG_HIT_CNT_EN
    ,
    output logic [NUM_CH*8-1:0]          HIT_CNT
`endif
);

    localparam int               CNT_W    = $clog2(OPC_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPC_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OPC_BITS);
    localparam logic [7:0]       PLS_LOAD = 8'(PLS_W);

    // synchroniser and edge-detect flops
    logic cs_s1, cs_s2, cs_d;
    logic sclk_s1, sclk_s2, sclk_d;
    logic mosi_s1, mosi_s2;

    logic cs_fall, cs_rise, sclk_rise;

    // frame state
    logic                frame_act;
    logic [CNT_W-1:0]    bit_cnt;
    logic [OPC_BITS-1:0] shift_reg;
    logic                opc_done;
    logic                rise_q;
    logic [NUM_CH-1:0]   armed;

    logic [NUM_CH-1:0]   hit_vec;
    logic [NUM_CH-1:0]   fire_vec;

    logic [7:0]          pls_cnt [NUM_CH];

    // two-flop synchronisers plus one delay flop for edge detection
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
            cs_d    <= 1'b0;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            cs_s1   <= SPI_CS;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            sclk_s1 <= SPI_CLK;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= SPI_MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    assign cs_fall   = cs_d & ~cs_s2;
    assign cs_rise   = ~cs_d & cs_s2;
    assign sclk_rise = sclk_s2 & ~sclk_d;

    // frame tracking and opcode shift; frame_act keeps a CS that was already low at reset release from decoding
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            frame_act <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            opc_done  <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            opc_done <= 1'b0;
            rise_q   <= cs_rise;
            if (cs_fall) begin
                frame_act <= 1'b1;
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (cs_rise) begin
                frame_act <= 1'b0;
            end else if (frame_act && sclk_rise && !cs_s2 && (bit_cnt != CNT_FULL)) begin
                shift_reg <= {shift_reg[OPC_BITS-2:0], mosi_s2};
                bit_cnt   <= bit_cnt + 1'b1;
                if (bit_cnt == CNT_LAST) begin
                    opc_done <= 1'b1;
                end
            end
        end
    end

    // per-channel masked compare of the completed opcode
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit_vec[i] = CH_EN[i] &&
                (((shift_reg ^ PAT[i*OPC_BITS +: OPC_BITS]) & ~MSK[i*OPC_BITS +: OPC_BITS]) == '0);
        end
    end

    // fire points: opcode completion in mode 0, delayed CS rise in mode 1
    always_comb begin
        fire_vec = '0;
        if (opc_done && !TRG_MODE) begin
            fire_vec = fire_vec | hit_vec;
        end
        if (rise_q && TRG_MODE) begin
            fire_vec = fire_vec | armed;
        end
    end

    // armed hit vector: cleared at frame start, captured at completion, consumed by a CS-rise fire
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            armed <= '0;
        end else if (cs_fall) begin
            armed <= '0;
        end else if (opc_done) begin
            armed <= hit_vec;
        end else if (rise_q) begin
            armed <= '0;
        end
    end

    // opcode strobe and held opcode value
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            OPC_VLD  <= 1'b0;
            OPC_DATA <= '0;
        end else begin
            OPC_VLD <= opc_done;
            if (opc_done) begin
                OPC_DATA <= shift_reg;
            end
        end
    end

    // pulse down-counters; a re-fire reloads so the pulse stretches without a gap
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pls_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (fire_vec[i]) begin
                    pls_cnt[i] <= PLS_LOAD;
                end else if (pls_cnt[i] != 8'd0) begin
                    pls_cnt[i] <= pls_cnt[i] - 8'd1;
                end
            end
        end
    end

    // pulse output is high while the channel counter is non-zero
    always_comb begin
        TRG_PLS = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            TRG_PLS[i] = (pls_cnt[i] != 8'd0);
        end
    end

`ifdef PTMCH_TRG_HIT_CNT_EN
    logic [7:0] hit_cnt [NUM_CH];

    // saturating per-channel fire counters, cleared only by reset
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hit_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (fire_vec[i] && (hit_cnt[i] != 8'hFF)) begin
                    hit_cnt[i] <= hit_cnt[i] + 8'd1;
                end
            end
        end
    end

    // pack the counters onto the output bus
    always_comb begin
        HIT_CNT = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            HIT_CNT[i*8 +: 8] = hit_cnt[i];
        end
    end
`endif

endmodule
